// File: rtl/avr_host_pkg.sv
// avr_host_pkg: state encoding and default sizing for the AVR-to-SRAM host bridge.
package avr_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_STROBE,
        ST_DONE
    } state_t;

    localparam int ADDR_W_DEF     = 21;
    localparam int DATA_W_DEF     = 8;
    localparam int STROBE_CYC_DEF = 2;

endpackage

// File: rtl/avr_host_piso.sv
// avr_host_piso: parallel-load, MSB-first serialiser that feeds the CPLD
// address shift register. Load takes priority over shift.
module avr_host_piso #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_shift,
    output logic         o_so
);

    logic [W-1:0] r_sreg;

    assign o_so = r_sreg[W-1];

    // Load a fresh word or move the next bit into the MSB position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/avr_host.sv
// avr_host: single-request host that shifts an SRAM address serially into
// the CPLD address register, then issues one read or write strobe.
// Optional feature: define AVR_HOST_ADDR_SKIP_EN to skip the address shift
// when the accepted address equals the last fully shifted one.
module avr_host
    import avr_host_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              avr_si,
    output logic              avr_sreg_en,
    output logic              avr_oe,
    output logic              avr_we,
    output logic [DATA_W-1:0] avr_data_o,
    output logic              avr_data_oe,
    input  logic [DATA_W-1:0] avr_data_i
);

    localparam int CNT_W = $clog2(ADDR_W + STROBE_CYC + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_skip;
    logic              w_shift;
    logic              w_so;

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_shift   = (r_state == ST_SHIFT);

    // Strobes and the data bus are decoded straight from state so that an
    // asynchronous reset returns every pin to its idle level at once.
    assign rsp_valid   = (r_state == ST_DONE);
    assign rsp_rdata   = r_rdata;
    assign avr_sreg_en = !w_shift;
    assign avr_si      = w_shift & w_so;
    assign avr_oe      = !((r_state == ST_STROBE) && !r_wr);
    assign avr_we      = !((r_state == ST_STROBE) && r_wr);
    assign avr_data_oe = r_wr && ((r_state == ST_SETTLE) || (r_state == ST_STROBE) ||
                                  (r_state == ST_DONE));
    assign avr_data_o  = avr_data_oe ? r_wdata : '0;

`ifdef AVR_HOST_ADDR_SKIP_EN
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_last_vld;

    assign w_skip = r_last_vld && (req_addr == r_last_addr);

    // Remember the address that the CPLD register currently holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
        end else if ((r_state == ST_SHIFT) && (w_next == ST_SETTLE)) begin
            r_last_vld  <= 1'b1;
            r_last_addr <= r_addr;
        end
    end

    // Keep the accepted address so it can be recorded once fully shifted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= req_addr;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the counter tracks position within SHIFT and STROBE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_skip ? ST_SETTLE : ST_SHIFT;
            ST_SHIFT:  if (r_cnt == SHIFT_LAST) w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_STROBE;
            ST_STROBE: if (r_cnt == STROBE_LAST) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Cycle counter restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SHIFT) || (r_state == ST_STROBE)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Request direction is control; it must be low in reset so no bus drive leaks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= 1'b0;
        end else if (w_accept) begin
            r_wr <= req_write;
        end
    end

    // Write data is only observed while avr_data_oe is high, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wdata <= req_wdata;
        end
    end

    // Read data is sampled on the edge that ends the final strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ((r_state == ST_STROBE) && !r_wr && (r_cnt == STROBE_LAST)) begin
            r_rdata <= avr_data_i;
        end
    end

    avr_host_piso #(
        .W(ADDR_W)
    ) u_piso (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_accept),
        .i_data (req_addr),
        .i_shift(w_shift),
        .o_so   (w_so)
    );

endmodule

// File: tb/tb_avr_host.sv
// tb_avr_host: directed bench for avr_host with default parameters.
// Define AVR_HOST_ADDR_SKIP_EN to exercise the address-skip build.
module tb_avr_host;

    localparam int AW = 21;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          avr_si;
    logic          avr_sreg_en;
    logic          avr_oe;
    logic          avr_we;
    logic [DW-1:0] avr_data_o;
    logic          avr_data_oe;
    logic [DW-1:0] avr_data_i;

    int n_cmp;
    int n_fail;

    typedef struct {
        int          rsp_cyc;
        logic [31:0] si_bits;
        int          si_cnt;
        int          si_bad;
        int          oe_low;
        int          we_low;
        int          both_low;
        int          doe_cnt;
        int          doe_first;
        int          we_first;
        int          doe_bad;
        logic [7:0]  rdata;
    } obs_t;

    avr_host dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .avr_si     (avr_si),
        .avr_sreg_en(avr_sreg_en),
        .avr_oe     (avr_oe),
        .avr_we     (avr_we),
        .avr_data_o (avr_data_o),
        .avr_data_oe(avr_data_oe),
        .avr_data_i (avr_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Issue one request from IDLE and record pin activity until rsp_valid (60-cycle bound).
    // Cycle 1 is the cycle right after the accepting edge.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; avr_data_i = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            avr_data_i = (avr_oe == 1'b0) ? rd : 8'h00;
            if (!avr_sreg_en) begin
                o.si_bits = {o.si_bits[30:0], avr_si};
                o.si_cnt++;
            end else if (avr_si) begin
                o.si_bad++;
            end
            if (!avr_oe) o.oe_low++;
            if (!avr_we) begin
                o.we_low++;
                if (o.we_first == 0) o.we_first = c;
            end
            if (!avr_oe && !avr_we) o.both_low++;
            if (avr_data_oe) begin
                o.doe_cnt++;
                if (o.doe_first == 0) o.doe_first = c;
                if (avr_data_o !== wd) o.doe_bad++;
            end
            if (rsp_valid) begin
                o.rsp_cyc = c;
                o.rdata = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h1FFFFF;
        req_wdata = 8'hFF; avr_data_i = 8'hFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", rsp_rdata); end
        n_cmp++; if (avr_si !== 1'b0) begin n_fail++; $display("FAIL rst_si got %b want 0", avr_si); end
        n_cmp++; if (avr_sreg_en !== 1'b1) begin n_fail++; $display("FAIL rst_sreg_en got %b want 1", avr_sreg_en); end
        n_cmp++; if (avr_oe !== 1'b1) begin n_fail++; $display("FAIL rst_oe got %b want 1", avr_oe); end
        n_cmp++; if (avr_we !== 1'b1) begin n_fail++; $display("FAIL rst_we got %b want 1", avr_we); end
        n_cmp++; if (avr_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data_o got %h want 00", avr_data_o); end
        n_cmp++; if (avr_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe got %b want 0", avr_data_oe); end
        req_valid = 1'b0; reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_read();
        obs_t o;
        run_txn(1'b0, 21'h1F3A55, 8'h00, 8'hAA, o);
        n_cmp++; if (o.rsp_cyc !== 25) begin n_fail++; $display("FAIL rd_rsp_cycle got %0d want 25", o.rsp_cyc); end
        n_cmp++; if (o.si_cnt !== 21) begin n_fail++; $display("FAIL rd_shift_len got %0d want 21", o.si_cnt); end
        n_cmp++; if (o.si_bits[AW-1:0] !== 21'h1F3A55) begin n_fail++; $display("FAIL rd_si_bits got %h want 1f3a55", o.si_bits[AW-1:0]); end
        n_cmp++; if (o.si_bad !== 0) begin n_fail++; $display("FAIL rd_si_outside_shift got %0d want 0", o.si_bad); end
        n_cmp++; if (o.oe_low !== 2) begin n_fail++; $display("FAIL rd_oe_low got %0d want 2", o.oe_low); end
        n_cmp++; if (o.we_low !== 0) begin n_fail++; $display("FAIL rd_we_low got %0d want 0", o.we_low); end
        n_cmp++; if (o.doe_cnt !== 0) begin n_fail++; $display("FAIL rd_data_oe got %0d want 0", o.doe_cnt); end
        n_cmp++; if (o.rdata !== 8'hAA) begin n_fail++; $display("FAIL rd_rdata got %h want aa", o.rdata); end
    endtask

    task automatic test_write();
        obs_t o;
        run_txn(1'b1, 21'h000001, 8'hEE, 8'h00, o);
        n_cmp++; if (o.rsp_cyc !== 25) begin n_fail++; $display("FAIL wr_rsp_cycle got %0d want 25", o.rsp_cyc); end
        n_cmp++; if (o.si_bits[AW-1:0] !== 21'h000001) begin n_fail++; $display("FAIL wr_si_bits got %h want 000001", o.si_bits[AW-1:0]); end
        n_cmp++; if (o.we_low !== 2) begin n_fail++; $display("FAIL wr_we_low got %0d want 2", o.we_low); end
        n_cmp++; if (o.we_first !== 23) begin n_fail++; $display("FAIL wr_we_first got %0d want 23", o.we_first); end
        n_cmp++; if (o.oe_low !== 0) begin n_fail++; $display("FAIL wr_oe_low got %0d want 0", o.oe_low); end
        n_cmp++; if (o.both_low !== 0) begin n_fail++; $display("FAIL wr_both_low got %0d want 0", o.both_low); end
        n_cmp++; if (o.doe_cnt !== 4) begin n_fail++; $display("FAIL wr_data_oe_len got %0d want 4", o.doe_cnt); end
        n_cmp++; if (o.doe_first !== 22) begin n_fail++; $display("FAIL wr_data_oe_first got %0d want 22", o.doe_first); end
        n_cmp++; if (o.doe_bad !== 0) begin n_fail++; $display("FAIL wr_data_o_value got %0d bad cycles want 0", o.doe_bad); end
        n_cmp++; if (o.rdata !== 8'hAA) begin n_fail++; $display("FAIL wr_rdata_held got %h want aa", o.rdata); end
    endtask

    task automatic test_back_to_back();
        int ready_cyc = 0;
        int rsp1 = 0;
        int rsp2 = 0;
        int shift_cnt = 0;
        int oe_low = 0;
        int we_low = 0;
        logic [7:0] rd1 = 8'h00;
        logic [7:0] rd2 = 8'h00;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h012345; req_wdata = 8'h00; avr_data_i = '0;
        @(posedge clk);
        #1 req_write = 1'b1; req_addr = 21'h1FFFFF; req_wdata = 8'h3C;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            avr_data_i = (avr_oe == 1'b0) ? 8'h5C : 8'h00;
            if (!avr_sreg_en) shift_cnt++;
            if (!avr_oe) oe_low++;
            if (!avr_we) we_low++;
            if (rsp_valid && rsp1 == 0) begin rsp1 = c; rd1 = rsp_rdata; end
            else if (rsp_valid && rsp2 == 0) begin rsp2 = c; rd2 = rsp_rdata; end
            if (req_ready && ready_cyc == 0) begin
                ready_cyc = c;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
            if (rsp2 != 0) break;
        end
        req_valid = 1'b0;
        n_cmp++; if (rsp1 !== 25) begin n_fail++; $display("FAIL b2b_rsp1_cycle got %0d want 25", rsp1); end
        n_cmp++; if (ready_cyc !== 26) begin n_fail++; $display("FAIL b2b_second_accept_cycle got %0d want 26", ready_cyc); end
        n_cmp++; if (rsp2 !== 51) begin n_fail++; $display("FAIL b2b_rsp2_cycle got %0d want 51", rsp2); end
        n_cmp++; if (rd1 !== 8'h5C) begin n_fail++; $display("FAIL b2b_rdata1 got %h want 5c", rd1); end
        n_cmp++; if (rd2 !== 8'h5C) begin n_fail++; $display("FAIL b2b_rdata_after_write got %h want 5c", rd2); end
        n_cmp++; if (shift_cnt !== 42) begin n_fail++; $display("FAIL b2b_shift_total got %0d want 42", shift_cnt); end
        n_cmp++; if (oe_low !== 2) begin n_fail++; $display("FAIL b2b_oe_low got %0d want 2", oe_low); end
        n_cmp++; if (we_low !== 2) begin n_fail++; $display("FAIL b2b_we_low got %0d want 2", we_low); end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        int spurious = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h1F3A55; req_wdata = 8'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (avr_sreg_en !== 1'b0) begin n_fail++; $display("FAIL abort_in_shift got sreg_en %b want 0", avr_sreg_en); end
        reset = 1'b1;
        #1;
        n_cmp++; if (avr_sreg_en !== 1'b1) begin n_fail++; $display("FAIL abort_sreg_en got %b want 1", avr_sreg_en); end
        n_cmp++; if (avr_si !== 1'b0) begin n_fail++; $display("FAIL abort_si got %b want 0", avr_si); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b want 0", req_ready); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rdata got %h want 00", rsp_rdata); end
        n_cmp++; if ({avr_oe, avr_we, avr_data_oe} !== 3'b110) begin n_fail++; $display("FAIL abort_strobes got %b want 110", {avr_oe, avr_we, avr_data_oe}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_release_ready got %b want 1", req_ready); end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL abort_spurious_rsp got %0d want 0", spurious); end
        run_txn(1'b0, 21'h0AAAAA, 8'h00, 8'h3C, o);
        n_cmp++; if (o.si_cnt !== 21) begin n_fail++; $display("FAIL abort_next_shift_len got %0d want 21", o.si_cnt); end
        n_cmp++; if (o.si_bits[AW-1:0] !== 21'h0AAAAA) begin n_fail++; $display("FAIL abort_next_si_bits got %h want 0aaaaa", o.si_bits[AW-1:0]); end
        n_cmp++; if (o.rsp_cyc !== 25) begin n_fail++; $display("FAIL abort_next_rsp_cycle got %0d want 25", o.rsp_cyc); end
        n_cmp++; if (o.rdata !== 8'h3C) begin n_fail++; $display("FAIL abort_next_rdata got %h want 3c", o.rdata); end
    endtask

    task automatic test_repeat_addr();
        obs_t o1;
        obs_t o2;
        obs_t o3;
        run_txn(1'b0, 21'h000100, 8'h00, 8'h81, o1);
        run_txn(1'b0, 21'h000100, 8'h00, 8'h42, o2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 21'h000100, 8'h00, 8'h18, o3);
        n_cmp++; if (o1.si_cnt !== 21) begin n_fail++; $display("FAIL rep_first_shift got %0d want 21", o1.si_cnt); end
        n_cmp++; if (o1.rsp_cyc !== 25) begin n_fail++; $display("FAIL rep_first_rsp got %0d want 25", o1.rsp_cyc); end
`ifdef AVR_HOST_ADDR_SKIP_EN
        n_cmp++; if (o2.si_cnt !== 0) begin n_fail++; $display("FAIL rep_second_shift got %0d want 0", o2.si_cnt); end
        n_cmp++; if (o2.rsp_cyc !== 4) begin n_fail++; $display("FAIL rep_second_rsp got %0d want 4", o2.rsp_cyc); end
`else
        n_cmp++; if (o2.si_cnt !== 21) begin n_fail++; $display("FAIL rep_second_shift got %0d want 21", o2.si_cnt); end
        n_cmp++; if (o2.rsp_cyc !== 25) begin n_fail++; $display("FAIL rep_second_rsp got %0d want 25", o2.rsp_cyc); end
`endif
        n_cmp++; if (o2.oe_low !== 2) begin n_fail++; $display("FAIL rep_second_oe_low got %0d want 2", o2.oe_low); end
        n_cmp++; if (o2.rdata !== 8'h42) begin n_fail++; $display("FAIL rep_second_rdata got %h want 42", o2.rdata); end
        n_cmp++; if (o3.si_cnt !== 21) begin n_fail++; $display("FAIL rep_after_reset_shift got %0d want 21", o3.si_cnt); end
        n_cmp++; if (o3.si_bits[AW-1:0] !== 21'h000100) begin n_fail++; $display("FAIL rep_after_reset_si got %h want 000100", o3.si_bits[AW-1:0]); end
        n_cmp++; if (o3.rsp_cyc !== 25) begin n_fail++; $display("FAIL rep_after_reset_rsp got %0d want 25", o3.rsp_cyc); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        avr_data_i = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_repeat_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
